// File: rtl/fifo_traffic_gen.sv
// Traffic initiator for a small synchronous FIFO: writes an incrementing tag sequence and reads it back
// using fill-then-drain, streaming or LFSR-random patterns. Optional feature macro: FIFO_TG_OVF_PROBE_EN.
module fifo_traffic_gen #(
  parameter int DW    = 4,
  parameter int DEPTH = 4,
  parameter int NW    = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [NW-1:0] num_items,
  input  logic          full,
  input  logic          empty,
  output logic          write_en,
  output logic [DW-1:0] write_data,
  output logic          read_en,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] wr_count,
  output logic [NW-1:0] rd_count
);

  localparam int         FCW       = $clog2(DEPTH + 1);
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    DRAIN  = 3'd2,
    STREAM = 3'd3,
    RAND   = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e         state_q, state_d;
  logic [NW-1:0]  wr_count_q, wr_count_d;
  logic [NW-1:0]  rd_count_q, rd_count_d;
  logic [NW-1:0]  num_items_q, num_items_d;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [FCW-1:0] fill_cnt_q, fill_cnt_d;
  logic           wr_phase_s, rd_phase_s, wr_inc_s, probe_s;
  logic           done_hit_s, fill_limit_s, fill_exit_s;
`ifdef FIFO_TG_OVF_PROBE_EN
  logic           probe_used_q, probe_used_d;
`endif

  // x^8+x^6+x^5+x^4+1, Fibonacci, shifting left.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  assign write_data = wr_count_q[DW-1:0];
  assign wr_count   = wr_count_q;
  assign rd_count   = rd_count_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

  // Port gating: read_en depends only on state and flags, write_en may use read_en.
  always_comb begin
    wr_phase_s = 1'b0;
    rd_phase_s = 1'b0;
    case (state_q)
      FILL:    wr_phase_s = (fill_cnt_q < FCW'(DEPTH));
      DRAIN:   rd_phase_s = 1'b1;
      STREAM: begin
        wr_phase_s = 1'b1;
        rd_phase_s = 1'b1;
      end
      RAND: begin
        wr_phase_s = lfsr_q[0];
        rd_phase_s = lfsr_q[1];
      end
      default: begin
        wr_phase_s = 1'b0;
        rd_phase_s = 1'b0;
      end
    endcase
    read_en  = rd_phase_s && (rd_count_q < num_items_q) && !empty && (rd_count_q < wr_count_q);
    wr_inc_s = wr_phase_s && (wr_count_q < num_items_q) && (!full || read_en);
`ifdef FIFO_TG_OVF_PROBE_EN
    probe_s  = (state_q == FILL) && full && !read_en && !probe_used_q;
`else
    probe_s  = 1'b0;
`endif
    write_en = wr_inc_s || probe_s;
  end

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    num_items_d = num_items_q;
    lfsr_d      = lfsr_q;
    wr_count_d  = wr_count_q + {{(NW-1){1'b0}}, wr_inc_s};
    rd_count_d  = rd_count_q + {{(NW-1){1'b0}}, read_en};
    fill_cnt_d  = fill_cnt_q + {{(FCW-1){1'b0}}, wr_inc_s};
    done_hit_s  = (rd_count_d == num_items_q);
`ifdef FIFO_TG_OVF_PROBE_EN
    probe_used_d = probe_used_q | probe_s;
    // Hold FILL one extra cycle so the probe sees the FIFO full; leave if it never fills.
    fill_limit_s = ((fill_cnt_d >= FCW'(DEPTH)) && probe_used_d) ||
                   ((fill_cnt_q >= FCW'(DEPTH)) && !full);
`else
    fill_limit_s = (fill_cnt_d >= FCW'(DEPTH));
`endif
    // A FIFO already full on entry would otherwise stall FILL forever.
    fill_exit_s = (wr_count_d == num_items_q) || fill_limit_s || (full && !write_en);

    case (state_q)
      IDLE: begin
        if (start) begin
          num_items_d = num_items;
          wr_count_d  = {NW{1'b0}};
          rd_count_d  = {NW{1'b0}};
          fill_cnt_d  = {FCW{1'b0}};
          lfsr_d      = LFSR_SEED;
`ifdef FIFO_TG_OVF_PROBE_EN
          probe_used_d = 1'b0;
`endif
          if (num_items == {NW{1'b0}}) begin
            state_d = DONE;
          end else begin
            case (mode)
              2'd1:    state_d = STREAM;
              2'd2:    state_d = RAND;
              default: state_d = FILL;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (done_hit_s) begin
          state_d = DONE;
        end else if (fill_exit_s) begin
          state_d = DRAIN;
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (done_hit_s) begin
          state_d = DONE;
        end else if (((rd_count_d == wr_count_q) || empty) && (wr_count_q < num_items_q)) begin
          state_d    = FILL;
          fill_cnt_d = {FCW{1'b0}};
        end else begin
          state_d = DRAIN;
        end
      end
      STREAM: begin
        if (done_hit_s) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      RAND: begin
        lfsr_d = lfsr_next(lfsr_q);
        if (done_hit_s) begin
          state_d = DONE;
        end else begin
          state_d = RAND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      wr_count_q  <= {NW{1'b0}};
      rd_count_q  <= {NW{1'b0}};
      num_items_q <= {NW{1'b0}};
      lfsr_q      <= LFSR_SEED;
      fill_cnt_q  <= {FCW{1'b0}};
`ifdef FIFO_TG_OVF_PROBE_EN
      probe_used_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      num_items_q <= num_items_d;
      lfsr_q      <= lfsr_d;
      fill_cnt_q  <= fill_cnt_d;
`ifdef FIFO_TG_OVF_PROBE_EN
      probe_used_q <= probe_used_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Directed bench for fifo_traffic_gen with a 4-deep FIFO occupancy model driving full/empty.
module tb_fifo_traffic_gen;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic [1:0] mode;
  logic [7:0] num_items;
  logic       full;
  logic       empty;
  logic       write_en;
  logic [3:0] write_data;
  logic       read_en;
  logic       busy;
  logic       done;
  logic [7:0] wr_count;
  logic [7:0] rd_count;

  int errors = 0;
  int checks = 0;

  int   fcount = 0;
  logic fifo_clr;
  int   bad_rd = 0;
  int   bad_wr = 0;
  int   done_pulses = 0;
  int   wr_cycles = 0;

  fifo_traffic_gen #(.DW(4), .DEPTH(4), .NW(8)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .mode       (mode),
    .num_items  (num_items),
    .full       (full),
    .empty      (empty),
    .write_en   (write_en),
    .write_data (write_data),
    .read_en    (read_en),
    .busy       (busy),
    .done       (done),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign full  = (fcount == 4);
  assign empty = (fcount == 0);

  // FIFO occupancy model: a write while full is accepted only alongside a read.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fcount <= 0;
    end else begin
      fcount <= fcount
              + ((write_en && (fcount < 4 || (read_en && fcount > 0))) ? 1 : 0)
              - ((read_en && fcount > 0) ? 1 : 0);
    end
  end

  // Protocol monitor.
  always @(posedge clk) begin
    if (read_en && empty) bad_rd <= bad_rd + 1;
    if (write_en && full && !read_en) bad_wr <= bad_wr + 1;
    if (write_en) wr_cycles <= wr_cycles + 1;
    if (done) done_pulses <= done_pulses + 1;
  end

  task automatic kick(input logic [1:0] m, input logic [7:0] n);
    mode      = m;
    num_items = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst_b = 1'b0;
    #1;
    checks++;
    if ({write_en, read_en, busy, done, wr_count, rd_count, write_data} !== 28'd0) begin
      errors++;
      $display("FAIL reset_values got we=%b re=%b busy=%b done=%b wr=%0d rd=%0d wd=%0d expected all 0",
               write_en, read_en, busy, done, wr_count, rd_count, write_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_we;
    logic [15:0] exp_re;
    int nw;
    exp_we = 16'h061E;  // writes in cycles 1-4 and 9-10
    exp_re = 16'h19E0;  // reads in cycles 5-8 and 11-12
    nw = 0;
    kick(2'd0, 8'd6);
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (write_en !== exp_we[i] || read_en !== exp_re[i] || done !== (i == 13)) begin
        errors++;
        $display("FAIL fill_drain cyc%0d got we=%b re=%b done=%b expected we=%b re=%b done=%b",
                 i, write_en, read_en, done, exp_we[i], exp_re[i], (i == 13));
      end
      if (write_en) begin
        checks++;
        if (write_data !== 4'(nw)) begin
          errors++;
          $display("FAIL fill_drain_tag write%0d got %0d expected %0d", nw, write_data, nw);
        end
        nw++;
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count !== 8'd6 || rd_count !== 8'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_drain_end got wr=%0d rd=%0d busy=%b expected 6 6 0", wr_count, rd_count, busy);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp_we;
    logic [15:0] exp_re;
    exp_we = 16'h07FE;  // cycles 1-10
    exp_re = 16'h0FFC;  // cycles 2-11
    kick(2'd1, 8'd10);
    for (int i = 1; i <= 14; i++) begin
      checks++;
      if (write_en !== exp_we[i] || read_en !== exp_re[i] || done !== (i == 12)) begin
        errors++;
        $display("FAIL stream cyc%0d got we=%b re=%b done=%b expected we=%b re=%b done=%b",
                 i, write_en, read_en, done, exp_we[i], exp_re[i], (i == 12));
      end
      if (write_en) begin
        checks++;
        if (write_data !== 4'(i - 1)) begin
          errors++;
          $display("FAIL stream_tag cyc%0d got %0d expected %0d", i, write_data, i - 1);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count !== 8'd10 || rd_count !== 8'd10) begin
      errors++;
      $display("FAIL stream_end got wr=%0d rd=%0d expected 10 10", wr_count, rd_count);
    end
  endtask

  task automatic test_rand();
    int d0, w0, k;
    d0 = done_pulses;
    w0 = wr_cycles;
    kick(2'd2, 8'd20);
    // lfsr A5,4A,95,2A -> write, read, write, read
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (write_en !== (i % 2 == 1) || read_en !== (i % 2 == 0)) begin
        errors++;
        $display("FAIL rand_head cyc%0d got we=%b re=%b expected we=%b re=%b",
                 i, write_en, read_en, (i % 2 == 1), (i % 2 == 0));
      end
      @(negedge clk);
    end
    k = 0;
    while (busy && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0 || wr_count !== 8'd20 || rd_count !== 8'd20) begin
      errors++;
      $display("FAIL rand_end got busy=%b wr=%0d rd=%0d expected 0 20 20", busy, wr_count, rd_count);
    end
    checks++;
    if (done_pulses - d0 !== 1 || wr_cycles - w0 !== 20) begin
      errors++;
      $display("FAIL rand_pulses got done=%0d writes=%0d expected 1 20", done_pulses - d0, wr_cycles - w0);
    end
  endtask

  task automatic test_zero_items();
    for (int m = 0; m < 4; m++) begin
      kick(2'(m), 8'd0);
      checks++;
      if (busy !== 1'b1 || done !== 1'b1 || write_en !== 1'b0 || read_en !== 1'b0) begin
        errors++;
        $display("FAIL zero_done mode%0d got busy=%b done=%b we=%b re=%b expected 1 1 0 0",
                 m, busy, done, write_en, read_en);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || write_en !== 1'b0 || wr_count !== 8'd0) begin
        errors++;
        $display("FAIL zero_idle mode%0d got busy=%b done=%b we=%b wr=%0d expected 0 0 0 0",
                 m, busy, done, write_en, wr_count);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int k, d0;
    kick(2'd1, 8'd10);
    k = 0;
    while (wr_count !== 8'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (wr_count !== 8'd5) begin
      errors++;
      $display("FAIL mid_reach got wr=%0d expected 5", wr_count);
    end
    d0 = done_pulses;
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({write_en, read_en, busy, done, wr_count, rd_count, write_data} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset got we=%b re=%b busy=%b done=%b wr=%0d rd=%0d wd=%0d expected all 0",
               write_en, read_en, busy, done, wr_count, rd_count, write_data);
    end
    fifo_clr = 1'b1;
    @(negedge clk);
    rst_b    = 1'b1;
    fifo_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (done_pulses !== d0) begin
      errors++;
      $display("FAIL mid_no_done got %0d pulses expected 0", done_pulses - d0);
    end
    kick(2'd1, 8'd3);
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (done !== (i == 5)) begin
        errors++;
        $display("FAIL restart_done cyc%0d got %b expected %b", i, done, (i == 5));
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count !== 8'd3 || rd_count !== 8'd3) begin
      errors++;
      $display("FAIL restart_end got wr=%0d rd=%0d expected 3 3", wr_count, rd_count);
    end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] exp_we;
    logic [15:0] exp_re;
    exp_we = 16'h061E;
    exp_re = 16'h19E0;
    kick(2'd0, 8'd6);
    for (int i = 1; i <= 15; i++) begin
      checks++;
      if (write_en !== exp_we[i] || read_en !== exp_re[i] || done !== (i == 13)) begin
        errors++;
        $display("FAIL busy_start cyc%0d got we=%b re=%b done=%b expected we=%b re=%b done=%b",
                 i, write_en, read_en, done, exp_we[i], exp_re[i], (i == 13));
      end
      if (i == 3) begin
        mode      = 2'd1;
        num_items = 8'd2;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (wr_count !== 8'd6 || rd_count !== 8'd6) begin
      errors++;
      $display("FAIL busy_start_end got wr=%0d rd=%0d expected 6 6", wr_count, rd_count);
    end
  endtask

  initial begin
    start     = 1'b0;
    mode      = 2'd0;
    num_items = 8'd0;
    rst_b     = 1'b1;
    fifo_clr  = 1'b0;
    test_reset();
    test_fill_drain();
    test_stream();
    test_rand();
    test_zero_items();
    test_reset_mid_run();
    test_start_while_busy();
    checks++;
    if (bad_rd !== 0 || bad_wr !== 0) begin
      errors++;
      $display("FAIL protocol got read_while_empty=%0d write_while_full=%0d expected 0 0", bad_rd, bad_wr);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
Traffic initiator that drives the write and read ports of the 4-deep, 4-bit synchronous FIFO. It generates write_data as an incrementing tag sequence and is the stimulus counterpart to the FIFO integrity checker. Each run is started by a one-cycle `start` and moves a programmed number of items through the FIFO using one of three traffic patterns. `done` pulses when every written item has been read back.

Parameters:
DW, 4, data width; must match the FIFO write_data/read_data width.
DEPTH, 4, FIFO depth; used only by the mode-0 fill phase limit.
NW, 8, width of num_items, wr_count and rd_count.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_b  in  1  reset; asynchronous, active-low.
start  in  1  begins a run; sampled in IDLE only.
mode  in  2  0 = fill-then-drain, 1 = streaming, 2 = LFSR random, 3 = same as 0.
num_items  in  NW  items to transfer; latched when `start` is accepted.
full  in  1  FIFO full flag.
empty  in  1  FIFO empty flag.
write_en  out  1  FIFO write request.
write_data  out  DW  FIFO write data.
read_en  out  1  FIFO read request.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a run completes.
wr_count  out  NW  writes issued in the current run.
rd_count  out  NW  reads issued in the current run.

Behaviour:
- Reset values:
  - state = IDLE.
  - wr_count, rd_count, latched num_items = 0.
  - lfsr = 8'hA5.
  - busy, done = 0.
  - write_en, read_en = 0; they are 0 in IDLE and DONE.
- write_data = wr_count[DW-1:0], combinational. The tag wraps modulo 2^DW.
- FSM states: IDLE, FILL, DRAIN, STREAM, RAND, DONE.
- IDLE:
  - On `start`: latch num_items and mode, clear both counters, reload lfsr = 8'hA5.
  - Next state: if num_items==0 -> DONE; else mode 0/3 -> FILL, mode 1 -> STREAM, mode 2 -> RAND.
- `start` outside IDLE is ignored.
- Read/write gating, combinational from current state and flags; no comb loop:
  - read_en = rd_phase && (rd_count < num_items) && !empty && (rd_count < wr_count).
  - write_en = wr_phase && (wr_count < num_items) && (!full || read_en).
  - A write while full is issued only together with a same-cycle read.
- Phase definitions:
  - FILL: wr_phase=1, rd_phase=0. Go to DRAIN when wr_count reaches num_items or DEPTH writes have been issued in this phase, whichever comes first.
  - DRAIN: rd_phase=1, wr_phase=0. When empty, or when rd_count == wr_count: go back to FILL if wr_count < num_items, else remain until the done condition is met.
  - STREAM: wr_phase=1 and rd_phase=1 every cycle.
  - RAND: wr_phase = lfsr[0], rd_phase = lfsr[1].
- LFSR:
  - Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form, shifted left.
  - New bit0 = b7^b5^b4^b3.
  - Advances every cycle in RAND only.
- wr_count increments on every cycle with write_en=1. rd_count increments on every cycle with read_en=1. Neither counter saturates past num_items, because of the gating above.
- Done condition: from any active state, rd_count == num_items (after the update) -> DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Counters hold their final values until the next start.
- Latency: first write_en is possible in the cycle immediately after start is accepted.
- Asynchronous reset mid-run: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: FIFO_TG_OVF_PROBE_EN.
- With the macro defined: in FILL, one extra cycle of write_en=1 is issued while full=1 and read_en=0 (a deliberate overflow attempt). It is issued once per run, at the first cycle full is seen. wr_count does not increment on that cycle and write_data repeats the current tag. This exercises the checker's overflow assertion.
- Without the macro: write_en is never asserted while full unless read_en=1.

Test Plan:
- Mode 0, num_items=6 -> writes tags 0,1,2,3; DRAIN reads 4; FILL writes 4,5; DRAIN reads 2; done pulses once; wr_count = rd_count = 6.
- Mode 1, num_items=10 with the FIFO model attached -> after the first write, write_en and read_en are high together each cycle; done pulses about 11 cycles after start; tags wrap 0..9 as 4-bit values.
- Mode 2, num_items=20 -> lfsr sequence starting 8'hA5 gates the traffic; no read while empty; no write while full without a read; done when rd_count=20.
- num_items=0, any mode -> IDLE, DONE, IDLE in 2 cycles; write_en and read_en stay 0.
- rst_b pulled low mid-STREAM with wr_count=5 -> all outputs return to 0 asynchronously; the next start with num_items=3 completes normally.
- `start` pulsed while busy -> ignored; num_items and mode are unchanged until the current run's done.
